// File: rtl/cfa_pkg.sv
// Shared types and helpers for the coherent frame accumulator.
// Holds the FSM state encoding, default widths and the sample sign-extension helper.
package cfa_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP, DONE} state_t;

  localparam int DATA_W_DEF = 14;
  localparam int ACC_W_DEF  = 64;

  function automatic logic signed [ACC_W_DEF-1:0] sext(input logic signed [DATA_W_DEF-1:0] x);
    return ACC_W_DEF'(x);
  endfunction

endpackage

// File: rtl/cfa_accum_ram.sv
// Simple dual-port accumulation RAM: one write port, one registered read port.
// Contents are never reset so the array maps onto block RAM.
module cfa_accum_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/coherent_frame_accumulator.sv
// Coherent averaging front end: sums N frames of M signed samples point-by-point
// in block RAM, then streams the M wide sums out one per clock.
module coherent_frame_accumulator
  import cfa_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MAX_POINTS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       n_frames,
  input  logic [31:0]       m_points,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic [31:0]       frames_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  localparam int ADDR_W = $clog2(MAX_POINTS);
  typedef logic signed [ACC_W-1:0] acc_t;

  // Reset asserts asynchronously, releases on a clock edge
  logic rst_meta, rst;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rst_meta, rst} <= 2'b11;
    else       {rst_meta, rst} <= {1'b0, rst_meta};
  end

  state_t            state, state_nx;
  logic [31:0]       n_lat;
  logic [ADDR_W-1:0] m_last, ptr, dump_addr;
  logic              cfg_ok, accept, dump_rd, last_pt, frames_full;

  logic              vld_p1, first_p1, dvld_p1;
  logic [ADDR_W-1:0] addr_p1;
  acc_t              sample_p1;
  logic              fwd_vld_p2;
  logic [ADDR_W-1:0] fwd_addr_p2;
  acc_t              fwd_data_p2;
  logic [ACC_W-1:0]  rd_data, result_hold;
  acc_t              base_p1, sum_p1;
  logic              fwd_hit;

  assign cfg_ok      = (m_points != 32'd0) && (m_points <= 32'(MAX_POINTS)) && (n_frames != 32'd0);
  assign frames_full = (frames_done == n_lat);
  assign accept      = (state == ACCUM) && enable && data_valid && !frames_full;
  assign dump_rd     = (state == DUMP) && enable;
  assign last_pt     = (ptr == m_last);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable && cfg_ok) state_nx = ACCUM;
      ACCUM:   if (!enable) state_nx = IDLE;
               else if (frames_full && !vld_p1) state_nx = DUMP;
      DUMP:    if (!enable) state_nx = IDLE;
               else if (dump_addr == m_last) state_nx = DONE;
      DONE:    if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // p1: RAM word for addr_p1 is available; a write still in flight to the
  // same address is taken from the forward register instead
  assign fwd_hit = fwd_vld_p2 && (fwd_addr_p2 == addr_p1);
  always_comb begin
    base_p1 = '0;
    if (!first_p1) base_p1 = fwd_hit ? fwd_data_p2 : acc_t'(rd_data);
    sum_p1 = base_p1 + sample_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      n_lat       <= '0;
      m_last      <= '0;
      ptr         <= '0;
      dump_addr   <= '0;
      frames_done <= '0;
      cfg_error   <= 1'b0;
      vld_p1      <= 1'b0;
      first_p1    <= 1'b0;
      addr_p1     <= '0;
      dvld_p1     <= 1'b0;
      fwd_vld_p2  <= 1'b0;
      fwd_addr_p2 <= '0;
      result_hold <= '0;
    end else begin
      state       <= state_nx;
      vld_p1      <= accept;
      dvld_p1     <= dump_rd;
      fwd_vld_p2  <= vld_p1;
      fwd_addr_p2 <= addr_p1;
      if (dvld_p1) result_hold <= rd_data;
      if (accept) begin
        addr_p1  <= ptr;
        first_p1 <= (frames_done == 32'd0);
        ptr      <= last_pt ? '0 : ptr + 1'b1;
        if (last_pt) frames_done <= frames_done + 32'd1;
      end
      if (state != DUMP) dump_addr <= '0;
      else if (dump_rd)  dump_addr <= dump_addr + 1'b1;
      if (state == IDLE) begin
        if (!enable) cfg_error <= 1'b0;
        else if (!cfg_ok) cfg_error <= 1'b1;
        else begin
          cfg_error   <= 1'b0;
          n_lat       <= n_frames;
          m_last      <= ADDR_W'(m_points - 32'd1);
          ptr         <= '0;
          frames_done <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sample_p1 <= sext(data_in);
    fwd_data_p2 <= sum_p1;
  end

  cfa_accum_ram #(
    .DEPTH  (MAX_POINTS),
    .WIDTH  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (vld_p1),
    .wr_addr (addr_p1),
    .wr_data (sum_p1),
    .rd_en   (accept || dump_rd),
    .rd_addr ((state == DUMP) ? dump_addr : ptr),
    .rd_data (rd_data)
  );

  assign result_valid = dvld_p1 && enable;
  assign result       = dvld_p1 ? rd_data : result_hold;
  assign busy         = (state == ACCUM) || (state == DUMP);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_coherent_frame_accumulator.sv
// Directed bench for coherent_frame_accumulator: hand-derived sums, a small
// per-point model for the random-duty runs, config rejection, abort and reset.
module tb_coherent_frame_accumulator;

  localparam int DATA_W = 14;
  localparam int ACC_W  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [31:0]       n_frames = '0;
  logic [31:0]       m_points = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic [31:0]       frames_done;
  logic              busy, done, cfg_error;

  always #5 clk = ~clk;

  coherent_frame_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .n_frames     (n_frames),
    .m_points     (m_points),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .result       (result),
    .result_valid (result_valid),
    .frames_done  (frames_done),
    .busy         (busy),
    .done         (done),
    .cfg_error    (cfg_error)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  logic [ACC_W-1:0] res_q [$];
  int               cyc_q [$];
  logic signed [ACC_W-1:0] model [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && result_valid) begin
      res_q.push_back(result);
      cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    res_q.delete();
    cyc_q.delete();
  endtask

  task automatic start(input int n, input int m);
    n_frames = n;
    m_points = m;
    enable   = 1'b1;
    tick();
    chk("start_busy", busy, 1);
  endtask

  // mode 0: sample k+1 at point k; 1: constant cval; 2: random
  task automatic feed(input int n, input int m, input int mode, input int cval, input int duty);
    int sent, budget, k;
    logic signed [DATA_W-1:0] d;
    sent = 0;
    budget = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    while (sent < n * m && budget < 5000) begin
      if ($urandom_range(99) < duty) begin
        k = sent % m;
        case (mode)
          0:       d = DATA_W'(k + 1);
          1:       d = DATA_W'(cval);
          default: d = DATA_W'($urandom_range(16383));
        endcase
        data_in    = d;
        data_valid = 1'b1;
        if (k < 16) model[k] = model[k] + ACC_W'(d);
        sent++;
      end else begin
        data_valid = 1'b0;
      end
      tick();
      budget++;
    end
    data_valid = 1'b0;
    chk("feed_count", sent, n * m);
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin
      tick();
      t++;
    end
    chk("done", done, 1);
    tick();
    tick();
  endtask

  task automatic check_results(input string tag, input int m);
    chk({tag, "_count"}, res_q.size(), m);
    if (res_q.size() == m) begin
      chk({tag, "_span"}, cyc_q[m-1] - cyc_q[0], m - 1);
      for (int k = 0; k < m; k++) chk({tag, "_res"}, res_q[k], model[k]);
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick();
    chk("stop_done", done, 0);
    clear_q();
  endtask

  int n_tab [4] = '{4, 4, 4, 0};
  int m_tab [4] = '{0, 2000, 1025, 8};

  initial begin
    #1;
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg", cfg_error, 0);
    chk("rst_frames", frames_done, 0);
    #22 reset = 1'b0;
    repeat (3) tick();

    // N=4, M=8, ramp data
    clear_q();
    start(4, 8);
    feed(4, 8, 0, 0, 100);
    wait_done(100);
    check_results("t1", 8);
    if (res_q.size() == 8)
      for (int k = 0; k < 8; k++) chk("t1_hand", res_q[k], 64'(4 * (k + 1)));
    chk("t1_frames", frames_done, 4);
    chk("t1_busy", busy, 0);
    stop_run();

    // M=1, back-to-back samples on one address
    start(16, 1);
    feed(16, 1, 1, -3, 100);
    wait_done(100);
    check_results("t2", 1);
    if (res_q.size() == 1) chk("t2_hand", res_q[0], -64'sd48);
    chk("t2_frames", frames_done, 16);
    stop_run();

    // sparse random data, then a second run replacing the sums
    for (int r = 0; r < 2; r++) begin
      start(3, 5);
      feed(3, 5, 2, 0, 30);
      wait_done(200);
      check_results(r == 0 ? "t3a" : "t3b", 5);
      stop_run();
    end

    // rejected configurations
    for (int i = 0; i < 4; i++) begin
      n_frames = n_tab[i];
      m_points = m_tab[i];
      enable   = 1'b1;
      tick();
      tick();
      chk("t4_cfg_err", cfg_error, 1);
      chk("t4_busy", busy, 0);
      enable = 1'b0;
      tick();
      chk("t4_cfg_clr", cfg_error, 0);
    end
    chk("t4_no_result", res_q.size(), 0);
    start(1, 1024);
    chk("t4_max_ok", cfg_error, 0);
    enable = 1'b0;
    tick();
    chk("t4_abort_busy", busy, 0);

    // abort in frame 2 of 4, then restart
    clear_q();
    start(4, 8);
    feed(2, 8, 0, 0, 100);
    for (int i = 0; i < 3; i++) begin
      data_in = DATA_W'(5);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    enable = 1'b0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_frames", frames_done, 2);
    repeat (4) tick();
    chk("t5_no_result", res_q.size(), 0);
    start(2, 3);
    feed(2, 3, 0, 0, 100);
    wait_done(100);
    check_results("t5", 3);
    if (res_q.size() == 3)
      for (int k = 0; k < 3; k++) chk("t5_hand", res_q[k], 64'(2 * (k + 1)));
    stop_run();

    // reset in the middle of the dump
    start(2, 4);
    feed(2, 4, 1, 100, 100);
    begin
      int t;
      t = 0;
      while (!result_valid && t < 20) begin
        tick();
        t++;
      end
    end
    chk("t6_in_dump", result_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_result", result, 0);
    chk("t6_rst_rv", result_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_frames", frames_done, 0);
    enable = 1'b0;
    #10 reset = 1'b0;
    repeat (3) tick();
    chk("t6_idle", busy, 0);
    clear_q();

    // large magnitude sums
    start(32, 4);
    feed(32, 4, 1, 8191, 100);
    wait_done(100);
    check_results("t6a", 4);
    if (res_q.size() == 4) chk("t6a_hand", res_q[3], 64'd262112);
    stop_run();
    start(64, 4);
    feed(64, 4, 1, -8192, 100);
    wait_done(100);
    check_results("t6b", 4);
    if (res_q.size() == 4) chk("t6b_hand", res_q[0], -64'sd524288);
    stop_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
